// File: rtl/vga_scanout.sv
// Framebuffer read side: 640x480@60 VGA timing from a 50 MHz clock with a 25 MHz pixel enable,
// 4x pixel replication from a 160x120x3 framebuffer, three-stage pixel pipeline to the DAC pins.
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned FB_W     = 160
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  output logic [14:0] rd_addr,
  output logic        rd_en,
  input  logic [2:0]  rd_data,
  output logic        vblank_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic          r_pix_en;
  logic [HW-1:0] r_h_cnt, w_h_nxt;
  logic [VW-1:0] r_v_cnt, w_v_nxt;
  logic [14:0]   r_rd_addr, w_addr, w_x_fb, w_y_fb;
  logic          r_rd_en;
  logic          r_vblank;
  logic          w_active, w_hs, w_vs;
  logic          r_hs_p1, r_vs_p1, r_blank_n_p1;
  logic          r_hs, r_vs, r_blank_n;
  logic [9:0]    r_red, r_grn, r_blu;

  always_comb begin
    w_h_nxt = r_h_cnt + HW'(1);
    w_v_nxt = r_v_cnt;
    if (r_h_cnt == H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
    end
  end

  // Each framebuffer texel covers a 4x4 block of screen pixels.
  assign w_x_fb = 15'(r_h_cnt >> 2);
  assign w_y_fb = 15'(r_v_cnt >> 2);
  assign w_addr = w_y_fb * 15'(FB_W) + w_x_fb;

  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs     = !((r_h_cnt >= H_SS) && (r_h_cnt <= H_SE));
  assign w_vs     = !((r_v_cnt >= V_SS) && (r_v_cnt <= V_SE));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_pix_en     <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_rd_addr    <= '0;
      r_rd_en      <= 1'b0;
      r_vblank     <= 1'b0;
      r_hs_p1      <= 1'b1;
      r_vs_p1      <= 1'b1;
      r_blank_n_p1 <= 1'b0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_blank_n    <= 1'b0;
      r_red        <= '0;
      r_grn        <= '0;
      r_blu        <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      r_vblank <= 1'b0;
      if (r_pix_en) begin
        r_h_cnt  <= w_h_nxt;
        r_v_cnt  <= w_v_nxt;
        r_vblank <= (w_h_nxt == '0) && (w_v_nxt == V_ACT);
        // Stage 1: read request plus timing flags for the same pixel.
        r_rd_en      <= w_active;
        if (w_active) begin
          r_rd_addr <= w_addr;
        end
        r_hs_p1      <= w_hs;
        r_vs_p1      <= w_vs;
        r_blank_n_p1 <= w_active;
        // Stage 2: rd_data arrived mid-period; register it with the delayed flags.
        r_hs         <= r_hs_p1;
        r_vs         <= r_vs_p1;
        r_blank_n    <= r_blank_n_p1;
        r_red        <= r_blank_n_p1 ? {10{rd_data[2]}} : '0;
        r_grn        <= r_blank_n_p1 ? {10{rd_data[1]}} : '0;
        r_blu        <= r_blank_n_p1 ? {10{rd_data[0]}} : '0;
      end
    end
  end

  assign rd_addr      = r_rd_addr;
  assign rd_en        = r_rd_en;
  assign vblank_start = r_vblank;
  assign VGA_CLK      = r_pix_en;
  assign VGA_HS       = r_hs;
  assign VGA_VS       = r_vs;
  assign VGA_BLANK_N  = r_blank_n;
  assign VGA_SYNC_N   = 1'b0;
  assign VGA_R        = r_red;
  assign VGA_G        = r_grn;
  assign VGA_B        = r_blu;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: full 640x480 geometry for line/address/data checks and a
// shrunken geometry instance so frame-level behaviour fits in a short run.
module tb_vga_scanout;

  logic clk;
  logic rst_big_n, rst_sml_n;
  logic hold_ones;

  logic [14:0] b_addr;
  logic        b_en, b_vb, b_clk, b_hs, b_vs, b_blank_n, b_sync_n;
  logic [2:0]  b_data;
  logic [9:0]  b_r, b_g, b_b;

  logic [14:0] s_addr;
  logic        s_en, s_vb, s_clk, s_hs, s_vs, s_blank_n, s_sync_n;
  logic [2:0]  s_data;
  logic [9:0]  s_r, s_g, s_b;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  vga_scanout u_big (
    .CLOCK_50    (clk),
    .resetn      (rst_big_n),
    .rd_addr     (b_addr),
    .rd_en       (b_en),
    .rd_data     (b_data),
    .vblank_start(b_vb),
    .VGA_CLK     (b_clk),
    .VGA_HS      (b_hs),
    .VGA_VS      (b_vs),
    .VGA_BLANK_N (b_blank_n),
    .VGA_SYNC_N  (b_sync_n),
    .VGA_R       (b_r),
    .VGA_G       (b_g),
    .VGA_B       (b_b)
  );

  // Small geometry: 24 pixels/line (16 active), 14 lines/frame (8 active), 672 clocks/frame.
  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .FB_W(160)
  ) u_sml (
    .CLOCK_50    (clk),
    .resetn      (rst_sml_n),
    .rd_addr     (s_addr),
    .rd_en       (s_en),
    .rd_data     (s_data),
    .vblank_start(s_vb),
    .VGA_CLK     (s_clk),
    .VGA_HS      (s_hs),
    .VGA_VS      (s_vs),
    .VGA_BLANK_N (s_blank_n),
    .VGA_SYNC_N  (s_sync_n),
    .VGA_R       (s_r),
    .VGA_G       (s_g),
    .VGA_B       (s_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory models: data valid one clock after the address.
  always @(posedge clk) begin
    b_data <= hold_ones ? 3'b111 : b_addr[2:0];
    s_data <= s_addr[2:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the falling edge following rising edge number 'target' since the last release.
  task automatic step_to(input int target);
    while (edge_n < target) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  function automatic logic [9:0] chan(input logic b);
    return b ? 10'h3FF : 10'h000;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hv[4];
    logic [14:0] exp_a;
    logic hs_prev, vs_prev;
    int hs_low, fall1, fall2;
    int vb_cnt, vb_first, vb_second, vs_low, vs_fall;

    hold_ones = 1'b0;
    rst_big_n = 1'b0;
    rst_sml_n = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_rd_addr", 32'(b_addr), 32'd0);
    check_eq("rst_rd_en", 32'(b_en), 32'd0);
    check_eq("rst_vga_clk", 32'(b_clk), 32'd0);
    check_eq("rst_hs", 32'(b_hs), 32'd1);
    check_eq("rst_vs", 32'(b_vs), 32'd1);
    check_eq("rst_blank_n", 32'(b_blank_n), 32'd0);
    check_eq("rst_rgb", {2'b0, b_r, b_g, b_b}, 32'd0);
    check_eq("rst_vblank", 32'(b_vb), 32'd0);
    check_eq("sync_n", 32'(b_sync_n), 32'd0);

    rst_big_n = 1'b1;
    edge_n    = 0;

    step_to(1);
    check_eq("vga_clk_e1", 32'(b_clk), 32'd1);
    step_to(2);
    check_eq("vga_clk_e2", 32'(b_clk), 32'd0);
    check_eq("first_rd_en", 32'(b_en), 32'd1);
    check_eq("first_rd_addr", 32'(b_addr), 32'd0);
    step_to(3);
    check_eq("blank_n_e3", 32'(b_blank_n), 32'd0);
    step_to(4);
    check_eq("blank_n_e4", 32'(b_blank_n), 32'd1);

    // Colour path on line 0: texel address h>>2, memory returns its low 3 bits.
    hv = '{4, 12, 20, 28};
    foreach (hv[i]) begin
      exp_a = 15'(hv[i] >> 2);
      step_to(2 * hv[i] + 4);
      check_eq($sformatf("r_h%0d", hv[i]), 32'(b_r), 32'(chan(exp_a[2])));
      check_eq($sformatf("g_h%0d", hv[i]), 32'(b_g), 32'(chan(exp_a[1])));
      check_eq($sformatf("b_h%0d", hv[i]), 32'(b_b), 32'(chan(exp_a[0])));
    end

    // Memory drives all ones through the blanked part of line 0.
    step_to(1280);
    hold_ones = 1'b1;
    step_to(1300);
    check_eq("blank_rgb", {2'b0, b_r, b_g, b_b}, 32'd0);
    check_eq("blank_n_h648", 32'(b_blank_n), 32'd0);
    hold_ones = 1'b0;

    hs_prev = b_hs;
    hs_low  = 0;
    fall1   = -1;
    fall2   = -1;
    for (int e = 1301; e <= 3000; e++) begin
      step_to(e);
      if (e <= 2900 && !b_hs) hs_low++;
      if (hs_prev && !b_hs) begin
        if (fall1 < 0) fall1 = e;
        else if (fall2 < 0) fall2 = e;
      end
      hs_prev = b_hs;
    end
    check_eq("hs_fall_edge", 32'(fall1), 32'd1316);
    check_eq("line_period", 32'(fall2 - fall1), 32'd1600);
    check_eq("hs_low_clocks", 32'(hs_low), 32'd192);

    step_to(6410);
    check_eq("addr_4_4", 32'(b_addr), 32'd161);
    check_eq("en_4_4", 32'(b_en), 32'd1);
    step_to(6412);
    check_eq("b_4_4", 32'(b_b), 32'h3FF);
    check_eq("r_4_4", 32'(b_r), 32'h0);
    step_to(7680);
    check_eq("addr_639_4", 32'(b_addr), 32'd319);
    step_to(7682);
    check_eq("en_640_4", 32'(b_en), 32'd0);
    check_eq("addr_hold", 32'(b_addr), 32'd319);

    // Counters are at (300,5); reset asynchronously between clock edges.
    step_to(8600);
    check_eq("pre_rst_addr", 32'(b_addr), 32'd234);
    check_eq("pre_rst_blank_n", 32'(b_blank_n), 32'd1);
    #1 rst_big_n = 1'b0;
    #1;
    check_eq("async_rd_addr", 32'(b_addr), 32'd0);
    check_eq("async_rd_en", 32'(b_en), 32'd0);
    check_eq("async_blank_n", 32'(b_blank_n), 32'd0);
    check_eq("async_rgb", {2'b0, b_r, b_g, b_b}, 32'd0);
    check_eq("async_hs_vs", {30'b0, b_hs, b_vs}, 32'd3);
    repeat (3) @(negedge clk);
    rst_big_n = 1'b1;
    edge_n    = 0;
    step_to(5);
    check_eq("restart_h", 32'(u_big.r_h_cnt), 32'd2);
    check_eq("restart_v", 32'(u_big.r_v_cnt), 32'd0);
    step_to(10);
    check_eq("restart_addr", 32'(b_addr), 32'd1);

    rst_sml_n = 1'b1;
    edge_n    = 0;
    vs_prev   = s_vs;
    vb_cnt    = 0;
    vb_first  = -1;
    vb_second = -1;
    vs_low    = 0;
    vs_fall   = -1;
    for (int e = 1; e <= 1400; e++) begin
      step_to(e);
      if (s_vb) begin
        vb_cnt++;
        if (vb_cnt == 1) vb_first = e;
        else if (vb_cnt == 2) vb_second = e;
      end
      if (e <= 672 && !s_vs) vs_low++;
      if (vs_prev && !s_vs && vs_fall < 0) vs_fall = e;
      vs_prev = s_vs;
      if (e == 672) begin
        check_eq("wrap_pre_en", 32'(s_en), 32'd0);
        check_eq("wrap_pre_addr", 32'(s_addr), 32'd163);
      end
      if (e == 674) begin
        check_eq("wrap_en", 32'(s_en), 32'd1);
        check_eq("wrap_addr", 32'(s_addr), 32'd0);
      end
      if (e == 675) check_eq("wrap_blank_lo", 32'(s_blank_n), 32'd0);
      if (e == 676) check_eq("wrap_blank_hi", 32'(s_blank_n), 32'd1);
    end
    check_eq("vblank_count", 32'(vb_cnt), 32'd2);
    check_eq("vblank_first", 32'(vb_first), 32'd384);
    check_eq("vblank_period", 32'(vb_second - vb_first), 32'd672);
    check_eq("vs_fall_edge", 32'(vs_fall), 32'd484);
    check_eq("vs_low_clocks", 32'(vs_low), 32'd96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
